// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential binary-to-BCD converter using iterative double-dabble
// (shift-and-add-3). One IN_W-bit value is converted per accepted request.
// The conversion takes IN_W shift cycles. The packed BCD result and its most
// significant nonzero decimal digit are registered on completion.
//
// Parameters:
//   IN_W  width of the binary input (1..8)
//   ND    number of BCD digits; requires 10^ND > 2^IN_W - 1
//
// Ports:
//   clk    in   1       rising-edge clock
//   rst    in   1       synchronous, active-high reset
//   start  in   1       conversion request, sampled only while idle
//   i      in   IN_W    binary value, captured when start is accepted
//   busy   out  1       high while a conversion is in progress
//   done   out  1       one-cycle pulse; bcd/msd updated
//   bcd    out  4*ND    packed BCD result, digit 0 (units) at [3:0]
//   msd    out  4       most significant nonzero digit (0 for value 0)
//
// Optional feature:
//   BIN2BCD_LZB_EN  when defined, leading zero digits above the most
//                   significant nonzero digit are written as 4'hF (blank).
//                   Digit 0 is never blanked. msd and timing are unchanged.
// -----------------------------------------------------------------------------
module bin2bcd_seq #(
  parameter int IN_W = 5,
  parameter int ND   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [IN_W-1:0]   i,
  output logic              busy,
  output logic              done,
  output logic [4*ND-1:0]   bcd,
  output logic [3:0]        msd
);

  localparam int CW = $clog2(IN_W + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t          state;
  logic [IN_W-1:0] sreg;
  logic [4*ND-1:0] acc;
  logic [CW-1:0]   cnt;

  logic [4*ND-1:0] acc_adj;
  logic [4*ND-1:0] acc_next;
  logic [4*ND-1:0] bcd_final;
  logic [3:0]      msd_next;
`ifdef BIN2BCD_LZB_EN
  logic            blank;
`endif

  // Next accumulator value for one double-dabble step, plus the values that
  // are registered when that step is the last one.
  // NOTE: every variable is given a default at the top of the block, so no
  // path leaves one unassigned and no latch is inferred.
  always_comb begin
    acc_adj = acc;
    for (int d = 0; d < ND; d++) begin
      if (acc[4*d +: 4] >= 4'd5)
        acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
    end

    acc_next = {acc_adj[4*ND-2:0], sreg[IN_W-1]};

    // Scanning upward, the last nonzero digit seen is the most significant.
    msd_next = 4'd0;
    for (int d = 0; d < ND; d++) begin
      if (acc_next[4*d +: 4] != 4'd0)
        msd_next = acc_next[4*d +: 4];
    end

    bcd_final = acc_next;
`ifdef BIN2BCD_LZB_EN
    // Blank zeros from the top down until the first nonzero digit; digit 0
    // is excluded so a zero value still shows a single 0.
    blank = 1'b1;
    for (int d = ND - 1; d >= 1; d--) begin
      if (acc_next[4*d +: 4] != 4'd0)
        blank = 1'b0;
      if (blank)
        bcd_final[4*d +: 4] = 4'hF;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sreg  <= '0;
      acc   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      bcd   <= '0;
      msd   <= 4'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sreg  <= i;
            acc   <= '0;
            cnt   <= CW'(IN_W);
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end

        SHIFT: begin
          acc <= acc_next;
          // Rotate the accumulator's outgoing top bit (always 0 for supported
          // parameters) into the vacated LSB of the shift register.
          sreg <= IN_W'({sreg, acc_adj[4*ND-1]});
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            bcd   <= bcd_final;
            msd   <= msd_next;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// tb_bin2bcd_seq
// Self-checking bench for bin2bcd_seq (IN_W=5, ND=2). Expected results come
// from a decimal reference model written with plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_bin2bcd_seq;

  localparam int IN_W = 5;
  localparam int ND   = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [IN_W-1:0]   i;
  logic              busy;
  logic              done;
  logic [4*ND-1:0]   bcd;
  logic [3:0]        msd;

  int n_checks = 0;
  int n_errors = 0;

  bin2bcd_seq #(.IN_W(IN_W), .ND(ND)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .i     (i),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd),
    .msd   (msd)
  );

  always #5 clk = ~clk;

  // Reference: decimal digits of v, optionally blanking leading zeros.
  function automatic logic [4*ND-1:0] ref_bcd(input int v);
    logic [4*ND-1:0] r;
    int x;
    int nsig;
    r = '0;
    x = v;
    nsig = 1;
    for (int k = 0; k < ND; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      if (x != 0) nsig = k + 1;
      x = x / 10;
    end
`ifdef BIN2BCD_LZB_EN
    for (int k = 1; k < ND; k++)
      if (k >= nsig) r[4*k +: 4] = 4'hF;
`endif
    return r;
  endfunction

  function automatic logic [3:0] ref_msd(input int v);
    int x;
    x = v;
    while (x >= 10) x = x / 10;
    return 4'(x);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full conversion starting from idle, with latency and result checks.
  task automatic run_conv(input int v, input string tag);
    int n;
    start = 1'b1;
    i     = IN_W'(v);
    step();
    start = 1'b0;
    i     = IN_W'($urandom);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    n = 0;
    while (!done && n < 20) begin
      step();
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(IN_W));
    check({tag, "_bcd"}, 32'(bcd), 32'(ref_bcd(v)));
    check({tag, "_msd"}, 32'(msd), 32'(ref_msd(v)));
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    step();
    check({tag, "_done_1cyc"}, 32'(done), 32'd0);
    check({tag, "_hold"}, 32'(bcd), 32'(ref_bcd(v)));
  endtask

  initial begin
    int n;
    int ndone;
    int v;

    // Reset with start asserted: nothing may start.
    rst   = 1'b1;
    start = 1'b1;
    i     = IN_W'(27);
    for (int k = 0; k < 2; k++) begin
      step();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_bcd", 32'(bcd), 32'h00);
      check("rst_msd", 32'(msd), 32'd0);
    end
    rst   = 1'b0;
    start = 1'b0;
    step();
    check("post_rst_idle", 32'(busy), 32'd0);

    // Single conversion of 27.
    run_conv(27, "single27");

    // Exhaustive sweep.
    for (int k = 0; k < 32; k++) run_conv(k, "sweep");

    // Randomized values with random idle gaps.
    for (int k = 0; k < 16; k++) begin
      n = int'($urandom_range(0, 3));
      for (int g = 0; g < n; g++) step();
      run_conv(int'($urandom_range(0, 31)), "rand");
    end

    // Start while busy is ignored.
    start = 1'b1;
    i     = IN_W'(13);
    step();
    start = 1'b0;
    step();
    start = 1'b1;
    i     = IN_W'(9);
    step();
    start = 1'b0;
    i     = '0;
    ndone = 0;
    for (int k = 0; k < 15; k++) begin
      if (done) begin
        ndone++;
        check("busy_start_bcd", 32'(bcd), 32'(ref_bcd(13)));
        check("busy_start_msd", 32'(msd), 32'(ref_msd(13)));
      end
      step();
    end
    check("busy_start_ndone", 32'(ndone), 32'd1);
    check("busy_start_idle", 32'(busy), 32'd0);

    // Back-to-back with start held high.
    start = 1'b1;
    i     = IN_W'(31);
    step();
    i = IN_W'(10);
    n = 0;
    while (!done && n < 20) begin
      step();
      n++;
    end
    check("b2b_first_lat", 32'(n), 32'(IN_W));
    check("b2b_first_bcd", 32'(bcd), 32'(ref_bcd(31)));
    step();
    start = 1'b0;
    check("b2b_second_accept", 32'(busy), 32'd1);
    n = 1;
    while (!done && n < 20) begin
      step();
      n++;
    end
    check("b2b_gap", 32'(n), 32'(IN_W + 1));
    check("b2b_second_bcd", 32'(bcd), 32'(ref_bcd(10)));
    check("b2b_second_msd", 32'(msd), 32'(ref_msd(10)));
    step();

    // Reset mid-conversion aborts.
    start = 1'b1;
    i     = IN_W'(25);
    step();
    start = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_bcd", 32'(bcd), 32'h00);
    check("abort_msd", 32'(msd), 32'd0);
    ndone = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (done) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'd0);
    v = 7;
    run_conv(v, "after_abort");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
